exc_sequencer: RTL and testbench
================================

// Module: exc_sequencer
// PURPOSE
//  Decides when exceptions, interrupts and ERET are taken, and sequences the CP0 register file around them.
//  Sits at the M stage, between the pipeline and CP0.
//  Arbitrates M-stage exception, CP0 interrupt request and ERET, then drives the following:
//   pipeline flush, PC redirect, EXL set/clear, EPC/BD/ExcCode writes.
//  Tracks handler residency and defers interrupts that arrive while M holds a bubble.
// PARAMETERS
//  HANDLER_PC  32'h0000_4180  exception/interrupt entry vector
//  CNT_W       16             width of the taken-event counter
// PORTS
//  clk          in   1      clock
//  reset        in   1      synchronous, active-high
//  valid_m      in   1      M stage holds a real instruction (0 = bubble)
//  pc_m         in   32     PC of M instruction
//  bd_m         in   1      M instruction is in a branch/jump delay slot
//  exccode_m    in   5      exception code carried to M (0 = none)
//  eret_m       in   1      M instruction is ERET
//  int_req      in   1      CP0 interrupt request (HWInt&IM, IE, !EXL already applied)
//  epc_in       in   32     current CP0 EPC
//  flush        out  1      kill F/D/E/M contents this cycle
//  redirect     out  1      load redirect_pc into PC this cycle
//  redirect_pc  out  32     HANDLER_PC or epc_in
//  exl_set      out  1      CP0 EXL<=1, capture exccode_out
//  exl_clr      out  1      CP0 EXL<=0, BD<=0
//  epc_we       out  1      CP0 EPC<=epc_out, BD<=bd_out
//  epc_out      out  32     {pc_m[31:2],2'b00} minus 4 if bd_m
//  bd_out       out  1      = bd_m at capture
//  exccode_out  out  5      exccode_m, or 0 for interrupt
//  in_handler   out  1      state==HANDLER
//  exc_count    out  CNT_W  number of taken exceptions/interrupts, wraps
// BEHAVIOUR
//  - Reset: state=IDLE. All outputs 0; exc_count=0. Reset wins over every event in the same cycle.
//  - State is registered. flush/redirect/exl_*/epc_we are Mealy outputs.
//    They are valid in the same cycle that the M instruction is present (zero latency); each is a 1-cycle pulse.
//  - States:
//    - IDLE:
//      - valid_m & exccode_m!=0 -> take exception, go to HANDLER.
//      - else valid_m & eret_m -> return: flush, redirect=epc_in, exl_clr; stay in IDLE.
//      - else int_req & valid_m -> take interrupt (code 0), go to HANDLER.
//      - else int_req & !valid_m -> go to WAIT_VALID; nothing is written.
//    - WAIT_VALID:
//      - first cycle with valid_m: take the event.
//        Exception if exccode_m!=0, else interrupt. The interrupt is taken even if int_req has since dropped (request latched).
//      - eret_m in this state is still treated as exception-or-interrupt, never as a return.
//    - HANDLER:
//      - int_req ignored.
//      - valid_m & eret_m -> return: flush, redirect=epc_in, exl_clr, go to IDLE.
//      - valid_m & exccode_m!=0 -> flush, redirect=HANDLER_PC, exl_set, exccode_out written.
//        epc_we=0, because EPC is preserved when EXL=1. Stay in HANDLER; exc_count increments.
//  - Take = flush=1, redirect=1, redirect_pc=HANDLER_PC, exl_set=1, epc_we=1 (except the HANDLER case), exc_count+1.
//  - Priority within one cycle: exception > eret > interrupt. An eret carrying exccode!=0 is handled as the exception.
//  - epc_out: 32-bit subtract, low two bits forced 0, wraps modulo 2^32.
//  - exc_count wraps from all-ones to 0.
//  - Bubble (valid_m=0) never triggers anything and never updates EPC.
//  - Reset in WAIT_VALID or HANDLER -> IDLE next edge; no pulses in the reset cycle.
// STRUCTURE
//  - Shared package cp0_pkg: state enum {IDLE,WAIT_VALID,HANDLER}; CP0 register indices SR=12, CAUSE=13, EPC=14, PRID=15; EXC_INT=5'd0.
//  - Sub-module exc_prio: combinational priority select (exception/eret/interrupt) -> one-hot event.
//  - FSM, EPC adder and counter stay in this module.
// TESTING
//  - exception: IDLE, valid_m=1, pc_m=0x3010, exccode_m=10, bd_m=0
//    -> same cycle flush=redirect=exl_set=epc_we=1, redirect_pc=0x4180, epc_out=0x3010, exccode_out=10; next state HANDLER; exc_count=1.
//  - delay-slot interrupt: int_req=1, valid_m=1, pc_m=0x3024, bd_m=1 -> epc_out=0x3020, bd_out=1, exccode_out=0.
//  - bubble deferral: int_req=1 with valid_m=0 for 3 cycles, then int_req=0 and valid_m=1, pc_m=0x3040
//    -> no pulses for 3 cycles; interrupt taken on cycle 4 with epc_out=0x3040.
//  - nested: in HANDLER, exccode_m=4 at pc_m=0x4190 -> redirect 0x4180, epc_we=0, state stays HANDLER.
//    Then eret_m -> redirect_pc=epc_in, exl_clr=1, state IDLE.
//  - simultaneous: IDLE with int_req=1, eret_m=1, exccode_m=12 -> exception path only, exccode_out=12; no exl_clr.
//  - reset in HANDLER with eret_m=1 -> no pulses that cycle; IDLE, exc_count=0 after.

Source files
------------

// File: rtl/cp0_pkg.sv
// rtl/cp0_pkg.sv - shared CP0 types, register indices and EPC helper
package cp0_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_VALID = 2'd1,
        HANDLER    = 2'd2
    } exc_state_t;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;
    localparam logic [4:0] EXC_INT   = 5'd0;

    // A delay-slot instruction restarts at its branch, one word earlier.
    function automatic logic [31:0] epc_of(input logic [31:0] pc, input logic bd);
        return {pc[31:2], 2'b00} - (bd ? 32'd4 : 32'd0);
    endfunction

endpackage

// File: rtl/exc_prio.sv
// rtl/exc_prio.sv - one-hot select of exception / eret / interrupt for the M stage
module exc_prio (
    input  logic valid_m,
    input  logic has_exc,
    input  logic eret_m,
    input  logic eret_en,
    input  logic irq,
    output logic sel_exc,
    output logic sel_eret,
    output logic sel_int
);

    // An eret that also carries an exception code is handled as the exception.
    assign sel_exc  = valid_m & has_exc;
    assign sel_eret = valid_m & ~has_exc & eret_m & eret_en;
    assign sel_int  = valid_m & ~has_exc & ~sel_eret & irq;

endmodule

// File: rtl/exc_sequencer.sv
// rtl/exc_sequencer.sv - M-stage exception/interrupt/ERET sequencer driving flush, redirect and CP0 writes
module exc_sequencer
    import cp0_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter int          CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             valid_m,
    input  logic [31:0]      pc_m,
    input  logic             bd_m,
    input  logic [4:0]       exccode_m,
    input  logic             eret_m,
    input  logic             int_req,
    input  logic [31:0]      epc_in,
    output logic             flush,
    output logic             redirect,
    output logic [31:0]      redirect_pc,
    output logic             exl_set,
    output logic             exl_clr,
    output logic             epc_we,
    output logic [31:0]      epc_out,
    output logic             bd_out,
    output logic [4:0]       exccode_out,
    output logic             in_handler,
    output logic [CNT_W-1:0] exc_count
);

    exc_state_t state, state_nxt;
    logic       eret_en, irq;
    logic       sel_exc, sel_eret, sel_int, take;

    // A pending request in WAIT_VALID is latched, so the live int_req no longer matters there.
    always_comb begin
        eret_en = 1'b1;
        irq     = int_req;
        case (state)
            WAIT_VALID: begin
                eret_en = 1'b0;
                irq     = 1'b1;
            end
            HANDLER:    irq = 1'b0;
            default:    ;
        endcase
    end

    exc_prio u_prio (
        .valid_m  (valid_m & ~reset),
        .has_exc  (exccode_m != EXC_INT),
        .eret_m   (eret_m),
        .eret_en  (eret_en),
        .irq      (irq),
        .sel_exc  (sel_exc),
        .sel_eret (sel_eret),
        .sel_int  (sel_int)
    );

    assign take = sel_exc | sel_int;

    always_comb begin
        state_nxt   = state;
        flush       = take | sel_eret;
        redirect    = take | sel_eret;
        redirect_pc = 32'd0;
        exl_set     = take;
        exl_clr     = sel_eret;
        epc_we      = take & (state != HANDLER);
        epc_out     = 32'd0;
        bd_out      = 1'b0;
        exccode_out = EXC_INT;
        if (sel_eret)
            redirect_pc = epc_in;
        else if (take)
            redirect_pc = HANDLER_PC;
        if (sel_exc)
            exccode_out = exccode_m;
        if (epc_we) begin
            epc_out = epc_of(pc_m, bd_m);
            bd_out  = bd_m;
        end
        case (state)
            IDLE: begin
                if (take)
                    state_nxt = HANDLER;
                else if (int_req & ~valid_m & ~reset)
                    state_nxt = WAIT_VALID;
            end
            WAIT_VALID: if (take) state_nxt = HANDLER;
            HANDLER:    if (sel_eret) state_nxt = IDLE;
            default:    state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            exc_count <= '0;
        end else begin
            state <= state_nxt;
            if (take)
                exc_count <= exc_count + 1'b1;
        end
    end

    assign in_handler = (state == HANDLER);

endmodule

// File: tb/tb_exc_sequencer.sv
// tb/tb_exc_sequencer.sv - randomized and directed self-checking bench for exc_sequencer
module tb_exc_sequencer;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset, valid_m, bd_m, eret_m, int_req;
    logic [31:0]      pc_m, epc_in;
    logic [4:0]       exccode_m;
    logic             flush, redirect, exl_set, exl_clr, epc_we, bd_out, in_handler;
    logic [31:0]      redirect_pc, epc_out;
    logic [4:0]       exccode_out;
    logic [CNT_W-1:0] exc_count;

    int total = 0;
    int bad   = 0;

    // Reference model: 0 = normal, 1 = interrupt pending, 2 = in handler.
    int mode  = 0;
    int count = 0;

    exc_sequencer #(.HANDLER_PC(32'h0000_4180), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .valid_m(valid_m), .pc_m(pc_m), .bd_m(bd_m),
        .exccode_m(exccode_m), .eret_m(eret_m), .int_req(int_req), .epc_in(epc_in),
        .flush(flush), .redirect(redirect), .redirect_pc(redirect_pc),
        .exl_set(exl_set), .exl_clr(exl_clr), .epc_we(epc_we), .epc_out(epc_out),
        .bd_out(bd_out), .exccode_out(exccode_out), .in_handler(in_handler),
        .exc_count(exc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic        e_take, e_ret, e_nest;
        logic [4:0]  e_code;
        logic [31:0] e_pc;
        int          nxt;
        e_take = 0; e_ret = 0; e_nest = 0; e_code = 0; nxt = mode;
        if (!reset && valid_m) begin
            if (exccode_m != 0) begin
                e_code = exccode_m;
                if (mode == 2) e_nest = 1; else e_take = 1;
                nxt = 2;
            end else if (mode == 1) begin
                e_take = 1; nxt = 2;
            end else if (eret_m) begin
                e_ret = 1; nxt = 0;
            end else if (mode == 0 && int_req) begin
                e_take = 1; nxt = 2;
            end
        end else if (!reset && mode == 0 && int_req) begin
            nxt = 1;
        end
        e_pc = {pc_m[31:2], 2'b00};
        if (bd_m) e_pc = e_pc - 32'd4;
        check("flush",       flush,       e_take | e_nest | e_ret);
        check("redirect",    redirect,    e_take | e_nest | e_ret);
        check("redirect_pc", redirect_pc, e_ret ? epc_in : (e_take | e_nest) ? 32'h4180 : 0);
        check("exl_set",     exl_set,     e_take | e_nest);
        check("exl_clr",     exl_clr,     e_ret);
        check("epc_we",      epc_we,      e_take);
        check("epc_out",     epc_out,     e_take ? e_pc : 0);
        check("bd_out",      bd_out,      e_take ? bd_m : 1'b0);
        check("exccode_out", exccode_out, e_code);
        check("in_handler",  in_handler,  mode == 2);
        check("exc_count",   exc_count,   count);
        if (reset) begin
            mode = 0; count = 0;
        end else begin
            if (e_take | e_nest) count = (count + 1) % (1 << CNT_W);
            mode = nxt;
        end
    end

    task automatic drive(input logic v, input logic [31:0] pc, input logic bd,
                         input logic [4:0] code, input logic er, input logic ir);
        valid_m = v; pc_m = pc; bd_m = bd; exccode_m = code; eret_m = er; int_req = ir;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; epc_in = 32'h0000_3010;
        drive(0, 0, 0, 0, 0, 0);
        step(); step();
        reset = 1'b0;

        drive(1, 32'h3010, 0, 5'd10, 0, 0); #3;
        check("t_exc_flush",  flush, 1);
        check("t_exc_epcwe",  epc_we, 1);
        check("t_exc_rpc",    redirect_pc, 32'h4180);
        check("t_exc_epc",    epc_out, 32'h3010);
        check("t_exc_code",   exccode_out, 10);
        step();
        check("t_exc_inh",    in_handler, 1);
        check("t_exc_cnt",    exc_count, 1);

        drive(1, 32'h4190, 0, 5'd4, 0, 0); #3;
        check("t_nest_rpc",   redirect_pc, 32'h4180);
        check("t_nest_epcwe", epc_we, 0);
        step();
        check("t_nest_inh",   in_handler, 1);

        epc_in = 32'h0000_3010;
        drive(1, 32'h4194, 0, 0, 1, 0); #3;
        check("t_eret_rpc",   redirect_pc, 32'h3010);
        check("t_eret_clr",   exl_clr, 1);
        step();
        check("t_eret_inh",   in_handler, 0);

        drive(1, 32'h3024, 1, 0, 0, 1); #3;
        check("t_ds_epc",     epc_out, 32'h3020);
        check("t_ds_bd",      bd_out, 1);
        check("t_ds_code",    exccode_out, 0);
        step();
        drive(1, 32'h4180, 0, 0, 1, 0); step();

        for (int i = 0; i < 3; i++) begin
            drive(0, 32'h0, 0, 0, 0, 1); #3;
            check("t_bub_quiet", {flush, redirect, exl_set, epc_we}, 0);
            step();
        end
        drive(1, 32'h3040, 0, 0, 0, 0); #3;
        check("t_bub_take",   flush, 1);
        check("t_bub_epc",    epc_out, 32'h3040);
        step();
        drive(1, 32'h4180, 0, 0, 1, 0); step();

        drive(1, 32'h3050, 0, 5'd12, 1, 1); #3;
        check("t_sim_code",   exccode_out, 12);
        check("t_sim_clr",    exl_clr, 0);
        step();
        check("t_sim_inh",    in_handler, 1);

        reset = 1'b1;
        drive(1, 32'h4184, 0, 0, 1, 0); #3;
        check("t_rst_quiet",  {flush, redirect, exl_clr, exl_set, epc_we}, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0); #3;
        check("t_rst_inh",    in_handler, 0);
        check("t_rst_cnt",    exc_count, 0);
        step();

        for (int i = 0; i < 3000; i++) begin
            reset  = ($urandom_range(99) < 2);
            epc_in = $urandom;
            drive($urandom_range(99) < 70, $urandom, $urandom_range(1),
                  ($urandom_range(99) < 20) ? 5'($urandom_range(31, 1)) : 5'd0,
                  $urandom_range(99) < 25, $urandom_range(99) < 30);
            step();
        end

        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        step();
        #5;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
